// File: rtl/shreg_tx_pkg.sv
// Shared types and constants for the shift-register TX scheduler.
// Optional build macro: PARITY_EN (appends an even-parity bit to each frame).
package shreg_tx_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/shreg_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches from (last+1) mod NREQ upward with wrap and
// returns a one-hot grant plus its encoded index. All-zero grant when disabled.
module rr_arbiter
  import shreg_tx_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      idx
);

  logic found;

  // Pick the first requesting index after the last winner.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    found = 1'b0;
    idx   = '0;
    gnt   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (en && !found && req[i] && (i == (int'(last) + k) % NREQ)) begin
          found = 1'b1;
          idx   = i[1:0];
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      gnt[i] = found && (idx == i[1:0]);
    end
  end

endmodule

// File: rtl/shreg_tx_scheduler.sv
// Fair, handshaked serializer: a round-robin arbiter loads one producer's byte
// into a shared left-shifting register, which is sent MSB-first on sdo.
// Optional build macro: PARITY_EN (adds a trailing even-parity bit per frame).
module shreg_tx_scheduler
  import shreg_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift_en,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  sdo,
  output logic                  sdo_valid,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic                  busy,
  output logic [1:0]            grant_id,
  output logic [WIDTH-1:0]      shreg
);

  localparam int            CW       = clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       grant_q, grant_d;
`ifdef PARITY_EN
  logic             par_q, par_d;
`endif

  logic             arb_en;
  logic [NREQ-1:0]  arb_gnt;
  logic [1:0]       arb_idx;
  logic [WIDTH-1:0] win_data;

  // Arbitration only happens in IDLE and only while the pipe is advancing.
  assign arb_en = shift_en && (state_q == IDLE);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req  (req_valid),
    .last (last_q),
    .en   (arb_en),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  assign req_ready = arb_gnt;
  assign grant_id  = grant_q;
  assign shreg     = shreg_q;

  // Select the winning requester's byte.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == i[1:0]) win_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Next-state, datapath updates and state-derived outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    last_d      = last_q;
    grant_d     = grant_q;
`ifdef PARITY_EN
    par_d       = par_q;
`endif
    busy        = 1'b0;
    sdo         = 1'b0;
    sdo_valid   = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;

    case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          shreg_d = win_data;
          grant_d = arb_idx;
          last_d  = arb_idx;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef PARITY_EN
          par_d   = ^win_data;
`endif
        end
      end
      SHIFT: begin
        busy        = 1'b1;
        sdo         = shreg_q[WIDTH-1];
        sdo_valid   = shift_en;
        frame_start = shift_en && (cnt_q == '0);
`ifndef PARITY_EN
        frame_end   = shift_en && (cnt_q == CNT_LAST);
`endif
        if (shift_en) begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
`ifdef PARITY_EN
            state_d = PAR;
`else
            state_d = IDLE;
            cnt_d   = '0;
`endif
          end
        end
      end
`ifdef PARITY_EN
      PAR: begin
        busy      = 1'b1;
        sdo       = par_q;
        sdo_valid = shift_en;
        frame_end = shift_en;
        if (shift_en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any frame and restores requester-0 priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      last_q  <= 2'(NREQ - 1);
      grant_q <= '0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      grant_q <= grant_d;
`ifdef PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_shreg_tx_scheduler.sv
// Self-checking bench for shreg_tx_scheduler: directed scenarios plus random
// traffic, all scored against a frame-level reference model.
module tb_shreg_tx_scheduler;

  localparam int W = 8;
  localparam int N = 2;
`ifdef PARITY_EN
  localparam int FLEN = W + 1;
`else
  localparam int FLEN = W;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           shift_en = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           sdo, sdo_valid, frame_start, frame_end, busy;
  logic [1:0]     grant_id;
  logic [W-1:0]   shreg;

  shreg_tx_scheduler #(.WIDTH(W), .NREQ(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .shift_en    (shift_en),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .sdo         (sdo),
    .sdo_valid   (sdo_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .busy        (busy),
    .grant_id    (grant_id),
    .shreg       (shreg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one frame in flight, described by its byte and bit position.
  bit           m_busy;
  int           m_pos, m_owner, m_last;
  logic [W-1:0] m_data;
  logic         m_par;

  // Values observed at the last tick's sample point.
  logic [N-1:0] obs_ready;
  logic         obs_sdo, obs_sv, obs_fs, obs_fe, obs_busy;

  task automatic model_reset();
    m_busy = 0; m_pos = 0; m_owner = 0; m_last = N - 1; m_data = '0; m_par = 1'b0;
  endtask

  // One clock: sample at negedge, score every output, advance the model.
  task automatic tick();
    logic [N-1:0] e_ready;
    logic         e_sdo, e_sv, e_fs, e_fe, e_busy;
    logic [W-1:0] e_shreg;
    logic [1:0]   e_gid;
    int           win;
    @(negedge clk);
    e_ready = '0; win = -1;
    e_sdo = 1'b0; e_sv = 1'b0; e_fs = 1'b0; e_fe = 1'b0; e_busy = 1'b0; e_shreg = '0;
    if (!m_busy) begin
      if (shift_en) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (win < 0 && req_valid[c]) win = c;
        end
      end
      if (win >= 0) e_ready[win] = 1'b1;
    end else begin
      e_busy  = 1'b1;
      e_sdo   = (m_pos < W) ? m_data[W-1-m_pos] : m_par;
      e_sv    = shift_en;
      e_fs    = shift_en && (m_pos == 0);
      e_fe    = shift_en && (m_pos == FLEN - 1);
      e_shreg = (m_pos >= W) ? '0 : (m_data << m_pos);
    end
    e_gid = m_owner[1:0];

    obs_ready = req_ready; obs_sdo = sdo; obs_sv = sdo_valid;
    obs_fs = frame_start; obs_fe = frame_end; obs_busy = busy;

    checks++; if (req_ready !== e_ready) begin errors++;
      $display("FAIL sb_req_ready t=%0t got=%b exp=%b", $time, req_ready, e_ready); end
    checks++; if (busy !== e_busy) begin errors++;
      $display("FAIL sb_busy t=%0t got=%b exp=%b", $time, busy, e_busy); end
    checks++; if (sdo_valid !== e_sv) begin errors++;
      $display("FAIL sb_sdo_valid t=%0t got=%b exp=%b", $time, sdo_valid, e_sv); end
    checks++; if (sdo !== e_sdo) begin errors++;
      $display("FAIL sb_sdo t=%0t got=%b exp=%b", $time, sdo, e_sdo); end
    checks++; if (frame_start !== e_fs) begin errors++;
      $display("FAIL sb_frame_start t=%0t got=%b exp=%b", $time, frame_start, e_fs); end
    checks++; if (frame_end !== e_fe) begin errors++;
      $display("FAIL sb_frame_end t=%0t got=%b exp=%b", $time, frame_end, e_fe); end
    checks++; if (grant_id !== e_gid) begin errors++;
      $display("FAIL sb_grant_id t=%0t got=%0d exp=%0d", $time, grant_id, e_gid); end
    checks++; if (shreg !== e_shreg) begin errors++;
      $display("FAIL sb_shreg t=%0t got=%h exp=%h", $time, shreg, e_shreg); end

    if (!m_busy) begin
      if (win >= 0) begin
        m_busy = 1; m_pos = 0; m_owner = win; m_last = win;
        m_data = req_data[win*W +: W];
        m_par  = ^m_data;
      end
    end else if (shift_en) begin
      m_pos++;
      if (m_pos == FLEN) begin m_busy = 0; m_pos = 0; end
    end
    @(posedge clk); #1;
  endtask

  // Pulse reset between edges and return at posedge+1.
  task automatic do_reset();
    rst_n = 1'b0; shift_en = 1'b0; req_valid = '0;
    model_reset();
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Send one frame from requester r and collect its bits.
  task automatic send_frame(input int r, input logic [W-1:0] d, output logic [FLEN-1:0] bits,
                            output int fe_at);
    req_valid = '0; req_valid[r] = 1'b1; req_data[r*W +: W] = d; shift_en = 1'b1;
    tick();
    req_valid = '0;
    bits = '0; fe_at = -1;
    for (int c = 1; c <= FLEN; c++) begin
      tick();
      if (obs_sv) bits = {bits[FLEN-2:0], obs_sdo};
      if (obs_fe) fe_at = c;
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    #2;
    checks++; if ({busy, sdo, sdo_valid, frame_start, frame_end} !== 5'b0) begin errors++;
      $display("FAIL reset_flags got=%b exp=00000", {busy, sdo, sdo_valid, frame_start, frame_end}); end
    checks++; if (grant_id !== 2'd0 || shreg !== '0 || req_ready !== '0) begin errors++;
      $display("FAIL reset_regs got gid=%0d shreg=%h ready=%b exp 0", grant_id, shreg, req_ready); end
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int fs_at, fe_at;
    logic [W-1:0] bits;
    req_valid = 2'b01; req_data[0 +: W] = 8'hA5; shift_en = 1'b1;
    tick();
    checks++; if (obs_ready !== 2'b01) begin errors++;
      $display("FAIL single_ready got=%b exp=01", obs_ready); end
    req_valid = '0; bits = '0; fs_at = -1; fe_at = -1;
    for (int c = 1; c <= FLEN; c++) begin
      tick();
      if (obs_sv && c <= W) bits = {bits[W-2:0], obs_sdo};
      if (obs_fs) fs_at = c;
      if (obs_fe) fe_at = c;
    end
    checks++; if (bits !== 8'hA5) begin errors++;
      $display("FAIL single_bits got=%h exp=a5", bits); end
    checks++; if (fs_at != 1 || fe_at != FLEN) begin errors++;
      $display("FAIL single_frame_marks got start=%0d end=%0d exp start=1 end=%0d", fs_at, fe_at, FLEN); end
    checks++; if (grant_id !== 2'd0) begin errors++;
      $display("FAIL single_grant got=%0d exp=0", grant_id); end
    tick();
    checks++; if (obs_busy !== 1'b0) begin errors++;
      $display("FAIL single_busy_after got=%b exp=0", obs_busy); end
  endtask

  task automatic test_contention();
    int seq[$];
    do_reset();
    req_valid = 2'b11; req_data = {8'h00, 8'hFF}; shift_en = 1'b1;
    for (int c = 0; c < 4 * (FLEN + 1); c++) begin
      tick();
      if (obs_ready == 2'b01) seq.push_back(0);
      else if (obs_ready == 2'b10) seq.push_back(1);
    end
    req_valid = '0;
    checks++; if (seq.size() != 4) begin errors++;
      $display("FAIL contention_count got=%0d exp=4", seq.size()); end
    for (int i = 0; i < seq.size() && i < 4; i++) begin
      checks++; if (seq[i] != i % 2) begin errors++;
        $display("FAIL contention_order idx=%0d got=%0d exp=%0d", i, seq[i], i % 2); end
    end
    while (busy) tick();
  endtask

  task automatic test_stall();
    logic [W-1:0] bits;
    int nbits, stalls;
    req_valid = 2'b01; req_data[0 +: W] = 8'hC3; shift_en = 1'b1;
    tick();
    req_valid = '0; bits = '0; nbits = 0; stalls = 0;
    for (int c = 0; c < 40 && nbits < FLEN; c++) begin
      shift_en = (nbits == 2 && stalls < 3) ? 1'b0 : 1'b1;
      tick();
      if (obs_sv) begin
        if (nbits < W) bits = {bits[W-2:0], obs_sdo};
        nbits++;
      end else if (obs_busy) stalls++;
    end
    shift_en = 1'b1;
    checks++; if (nbits != FLEN) begin errors++;
      $display("FAIL stall_timeout got=%0d bits exp=%0d", nbits, FLEN); end
    checks++; if (bits !== 8'hC3) begin errors++;
      $display("FAIL stall_bits got=%h exp=c3", bits); end
    checks++; if (stalls != 3) begin errors++;
      $display("FAIL stall_cycles got=%0d exp=3", stalls); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [FLEN-1:0] bits;
    int fe_at;
    req_valid = 2'b01; req_data[0 +: W] = 8'h5A; shift_en = 1'b1;
    tick();
    req_valid = '0;
    for (int c = 0; c < 4; c++) tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if ({busy, sdo, sdo_valid, frame_start, frame_end, grant_id, shreg, req_ready} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got busy=%b sdo=%b sv=%b fs=%b fe=%b gid=%0d shreg=%h ready=%b exp 0",
               busy, sdo, sdo_valid, frame_start, frame_end, grant_id, shreg, req_ready);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(1, 8'h96, bits, fe_at);
    checks++; if (bits[FLEN-1 -: W] !== 8'h96 || fe_at != FLEN) begin errors++;
      $display("FAIL midreset_next_frame got bits=%h end=%0d exp bits=96 end=%0d", bits[FLEN-1 -: W], fe_at, FLEN); end
    checks++; if (grant_id !== 2'd1) begin errors++;
      $display("FAIL midreset_grant got=%0d exp=1", grant_id); end
    tick();
  endtask

  task automatic test_idle_gating();
    do_reset();
    shift_en = 1'b0; req_valid = 2'b11; req_data = {8'h11, 8'h22};
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (obs_ready !== 2'b00 || obs_busy !== 1'b0) begin errors++;
        $display("FAIL gating_hold got ready=%b busy=%b exp 00/0", obs_ready, obs_busy); end
    end
    shift_en = 1'b1;
    tick();
    checks++; if (obs_ready !== 2'b01) begin errors++;
      $display("FAIL gating_release got=%b exp=01", obs_ready); end
    req_valid = '0;
    for (int c = 0; c <= FLEN; c++) tick();
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    logic [FLEN-1:0] bits;
    int fe_at;
    send_frame(0, 8'h07, bits, fe_at);
    checks++; if (bits !== 9'b0000_0111_1 || fe_at != 9) begin errors++;
      $display("FAIL parity_07 got bits=%b end=%0d exp bits=000001111 end=9", bits, fe_at); end
    tick();
    send_frame(0, 8'h03, bits, fe_at);
    checks++; if (bits !== 9'b0000_0011_0) begin errors++;
      $display("FAIL parity_03 got=%b exp=000000110", bits); end
    tick();
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      shift_en  = ($urandom_range(0, 4) != 0);
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      req_data  = (N*W)'($urandom());
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_reset_mid();
    test_idle_gating();
`ifdef PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
